// File: rtl/cnn_conv_engine.sv
// cnn_conv_engine: 3x3 binary convolution over a 28x28 binary image,
// feature counting per two-row band, and argmax over the 13 bands.
module cnn_conv_engine (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_start,
    output logic [4:0]  o_row_addr,
    input  logic [27:0] i_row_data,
    input  logic [8:0]  i_kernel,
    input  logic [3:0]  i_threshold,
    output logic        o_busy,
    output logic        o_done,
    output logic [3:0]  o_result
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CONV,
        FETCH,
        ARGMAX,
        DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        start_q;
    logic        armed;
    logic        start_edge;

    logic [8:0]  kernel_q;
    logic [3:0]  thr_q;

    logic [27:0] lb0;
    logic [27:0] lb1;
    logic [27:0] lb2;

    logic [4:0]  out_row;
    logic [4:0]  col;
    logic [3:0]  band;

    logic [5:0]  cnt [13];

    logic [3:0]  scan;
    logic [3:0]  best_idx;
    logic [5:0]  best_cnt;
    logic [5:0]  scan_cnt;
    logic        scan_gt;
    logic [3:0]  best_nxt;

    logic [27:0] s0;
    logic [27:0] s1;
    logic [27:0] s2;
    logic [8:0]  win;
    logic [8:0]  match;
    logic [3:0]  match_cnt;
    logic        feature;

    logic        col_last;
    logic        row_last;

    // armed blocks a start that was already high when reset released
    assign start_edge = i_start & ~start_q & armed;
    assign band       = out_row[4:1];
    assign col_last   = (col == 5'd25);
    assign row_last   = (out_row == 5'd25);

    // state register
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode and status outputs
    always_comb begin
        state_nxt = state;
        o_busy    = 1'b1;
        o_done    = 1'b0;
        unique case (state)
            IDLE: begin
                o_busy = 1'b0;
                if (start_edge) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (col == 5'd2) begin
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (col_last) begin
                    state_nxt = row_last ? ARGMAX : FETCH;
                end
            end
            FETCH: begin
                state_nxt = CONV;
            end
            ARGMAX: begin
                if (scan == 4'd12) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_done    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // window extraction at col and XNOR popcount against the kernel
    always_comb begin
        s0        = lb0 << col;
        s1        = lb1 << col;
        s2        = lb2 << col;
        win       = {s0[27:25], s1[27:25], s2[27:25]};
        match     = ~(win ^ kernel_q);
        match_cnt = 4'd0;
        for (int i = 0; i < 9; i++) begin
            match_cnt = match_cnt + {3'b000, match[i]};
        end
        feature   = (match_cnt >= thr_q);
    end

    // argmax compare: strictly greater keeps the lowest index on ties
    always_comb begin
        scan_cnt = 6'd0;
        for (int i = 0; i < 13; i++) begin
            if (scan == 4'(i)) begin
                scan_cnt = cnt[i];
            end
        end
        scan_gt  = (scan_cnt > best_cnt);
        best_nxt = scan_gt ? scan : best_idx;
    end

    // datapath: start edge, line buffers, counters, scan and result
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            start_q    <= 1'b0;
            armed      <= 1'b0;
            kernel_q   <= 9'd0;
            thr_q      <= 4'd0;
            lb0        <= 28'd0;
            lb1        <= 28'd0;
            lb2        <= 28'd0;
            out_row    <= 5'd0;
            col        <= 5'd0;
            scan       <= 4'd0;
            best_idx   <= 4'd0;
            best_cnt   <= 6'd0;
            o_row_addr <= 5'd0;
            o_result   <= 4'd0;
            for (int i = 0; i < 13; i++) begin
                cnt[i] <= 6'd0;
            end
        end else begin
            start_q <= i_start;
            if (!i_start) begin
                armed <= 1'b1;
            end
            unique case (state)
                IDLE: begin
                    o_row_addr <= 5'd0;
                    if (start_edge) begin
                        kernel_q <= i_kernel;
                        thr_q    <= i_threshold;
                        col      <= 5'd0;
                        out_row  <= 5'd0;
                        for (int i = 0; i < 13; i++) begin
                            cnt[i] <= 6'd0;
                        end
                    end
                end
                LOAD: begin
                    case (col)
                        5'd0:    lb0 <= i_row_data;
                        5'd1:    lb1 <= i_row_data;
                        default: lb2 <= i_row_data;
                    endcase
                    if (col == 5'd2) begin
                        col     <= 5'd0;
                        out_row <= 5'd0;
                    end else begin
                        col        <= col + 5'd1;
                        o_row_addr <= col + 5'd1;
                    end
                end
                CONV: begin
                    if (feature) begin
                        for (int i = 0; i < 13; i++) begin
                            if (band == 4'(i)) begin
                                cnt[i] <= cnt[i] + 6'd1;
                            end
                        end
                    end
                    if (col_last) begin
                        col <= 5'd0;
                        if (row_last) begin
                            scan     <= 4'd0;
                            best_idx <= 4'd0;
                            best_cnt <= 6'd0;
                        end else begin
                            o_row_addr <= out_row + 5'd3;
                        end
                    end else begin
                        col <= col + 5'd1;
                    end
                end
                FETCH: begin
                    lb0     <= lb1;
                    lb1     <= lb2;
                    lb2     <= i_row_data;
                    out_row <= out_row + 5'd1;
                    col     <= 5'd0;
                end
                ARGMAX: begin
                    best_idx <= best_nxt;
                    if (scan_gt) begin
                        best_cnt <= scan_cnt;
                    end
                    scan <= scan + 4'd1;
                    if (scan == 4'd12) begin
                        o_result <= best_nxt;
                    end
                end
                DONE: begin
                    o_row_addr <= 5'd0;
                end
                default: begin
                    o_row_addr <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cnn_conv_engine.sv
// tb_cnn_conv_engine: directed vector table plus hand-written
// sequences for restart-while-busy and mid-run reset.
module tb_cnn_conv_engine;

    logic        i_Clk = 1'b0;
    logic        i_Rst;
    logic        i_start;
    logic [4:0]  o_row_addr;
    logic [27:0] i_row_data;
    logic [8:0]  i_kernel;
    logic [3:0]  i_threshold;
    logic        o_busy;
    logic        o_done;
    logic [3:0]  o_result;

    logic [27:0] img [28];

    int checks = 0;
    int fails  = 0;

    typedef struct {
        string      name;
        int         pat;
        logic [8:0] k;
        logic [3:0] t;
        logic [3:0] exp;
    } vec_t;

    vec_t vecs [12];

    cnn_conv_engine dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_start     (i_start),
        .o_row_addr  (o_row_addr),
        .i_row_data  (i_row_data),
        .i_kernel    (i_kernel),
        .i_threshold (i_threshold),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_result    (o_result)
    );

    always #5 i_Clk = ~i_Clk;

    // row store model: data valid in the same cycle as the address
    always_comb begin
        i_row_data = (o_row_addr < 5'd28) ? img[o_row_addr] : 28'd0;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_image(input int pat);
        for (int r = 0; r < 28; r++) img[r] = 28'd0;
        case (pat)
            1: for (int r = 20; r <= 22; r++) img[r] = 28'hFFFFFFF;
            2: begin
                for (int r = 2; r <= 4; r++) img[r] = 28'hFFFFFFF;
                for (int r = 22; r <= 24; r++) img[r] = 28'hFFFFFFF;
            end
            3: for (int r = 25; r <= 27; r++) img[r] = 28'hFFFFFFF;
            4: for (int r = 6; r <= 8; r++) img[r] = 28'hFFFFFFF;
            5: for (int r = 10; r <= 12; r++) img[r] = 28'hE000000;
            6: img[14] = 28'h0000004;
            7: img[14] = 28'h8000000;
            default: ;
        endcase
    endtask

    // one run; kernel/threshold inputs are scrambled once the run is going
    task automatic run_check(input string name, input logic [8:0] k,
                             input logic [3:0] t, input logic [3:0] exp,
                             input int restart_at);
        int cyc;
        int lat;
        int busy;
        int dones;
        int res;
        lat   = -1;
        busy  = 0;
        dones = 0;
        res   = -1;
        @(negedge i_Clk);
        i_kernel    = k;
        i_threshold = t;
        i_start     = 1'b0;
        @(negedge i_Clk);
        i_start = 1'b1;
        for (cyc = 1; cyc <= 740; cyc++) begin
            @(negedge i_Clk);
            if (o_busy) busy++;
            if (o_done) begin
                dones++;
                lat = cyc - 1;
                res = int'(o_result);
            end
            if (cyc == 3) i_start = 1'b0;
            if (cyc == 10) begin
                i_kernel    = ~k;
                i_threshold = ~t;
            end
            if (restart_at > 0 && cyc == restart_at) i_start = 1'b1;
            if (restart_at > 0 && cyc == restart_at + 1) i_start = 1'b0;
        end
        check({name, " latency"}, lat, 717);
        check({name, " busy"}, busy, 718);
        check({name, " done count"}, dones, 1);
        check({name, " result"}, res, int'(exp));
        check({name, " result hold"}, int'(o_result), int'(exp));
        check({name, " idle addr"}, int'(o_row_addr), 0);
    endtask

    initial begin
        int d;
        int b;

        vecs[0]  = '{"zero img k000 t9",   0, 9'h000, 4'd9,  4'd0};
        vecs[1]  = '{"rows20-22",          1, 9'h1FF, 4'd9,  4'd10};
        vecs[2]  = '{"tie bands 1/11",     2, 9'h1FF, 4'd9,  4'd1};
        vecs[3]  = '{"thr0",               1, 9'h1FF, 4'd0,  4'd0};
        vecs[4]  = '{"thr10",              1, 9'h1FF, 4'd10, 4'd0};
        vecs[5]  = '{"thr15",              1, 9'h1FF, 4'd15, 4'd0};
        vecs[6]  = '{"last band",          3, 9'h1FF, 4'd9,  4'd12};
        vecs[7]  = '{"rows6-8 t6",         4, 9'h1FF, 4'd6,  4'd3};
        vecs[8]  = '{"col0 block",         5, 9'h1FF, 4'd9,  4'd5};
        vecs[9]  = '{"pixel k top-left",   6, 9'h100, 4'd9,  4'd7};
        vecs[10] = '{"pixel col0 k dc2",   7, 9'h040, 4'd9,  4'd0};
        vecs[11] = '{"pixel k bot-left",   6, 9'h004, 4'd9,  4'd6};

        i_Rst       = 1'b1;
        i_start     = 1'b0;
        i_kernel    = 9'h0;
        i_threshold = 4'h0;
        set_image(0);
        repeat (3) @(negedge i_Clk);
        check("reset busy", int'(o_busy), 0);
        check("reset done", int'(o_done), 0);
        check("reset result", int'(o_result), 0);
        check("reset addr", int'(o_row_addr), 0);
        i_Rst = 1'b0;

        for (int v = 0; v < 12; v++) begin
            set_image(vecs[v].pat);
            run_check(vecs[v].name, vecs[v].k, vecs[v].t, vecs[v].exp, 0);
        end

        set_image(1);
        run_check("restart at 100", 9'h1FF, 4'd9, 4'd10, 100);

        // mid-run reset with i_start held high through and after it
        set_image(2);
        run_check("pre-reset run", 9'h1FF, 4'd9, 4'd1, 0);
        @(negedge i_Clk);
        i_start = 1'b0;
        @(negedge i_Clk);
        i_start = 1'b1;
        for (int c = 1; c < 300; c++) @(negedge i_Clk);
        check("busy before reset", int'(o_busy), 1);
        i_Rst = 1'b1;
        @(negedge i_Clk);
        check("abort busy", int'(o_busy), 0);
        check("abort done", int'(o_done), 0);
        check("abort result", int'(o_result), 0);
        check("abort addr", int'(o_row_addr), 0);
        i_Rst = 1'b0;
        d = 0;
        b = 0;
        for (int c = 0; c < 800; c++) begin
            @(negedge i_Clk);
            if (o_done) d++;
            if (o_busy) b++;
        end
        check("no done after abort", d, 0);
        check("held start ignored", b, 0);

        set_image(1);
        run_check("after reset", 9'h1FF, 4'd9, 4'd10, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
